i8035_ext_bus_resp: RTL and testbench

// - External-bus responder for the T8035 soft CPU: the memory/peripheral end of its multiplexed bus.
// - Captures the low address on ALE and, on PSENn/RDn, fetches a byte over a req/ack memory port (BRAM or SDRAM arbiter) and drives it back on the CPU data-in bus.
// - On WRn it emits a one-cycle write strobe for a latch or RAM.
// - Sits beside the CPU wrapper in the sound subsystem; all signals are synchronous to the CPU clock.

---
 rtl/i8035_ext_bus_resp.sv | 179 +++++++++++++++++
 tb/tb_i8035_ext_bus_resp.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i8035_ext_bus_resp.sv
// External-bus responder for the T8035 soft CPU: latches the low address on ALE, serves PSENn/RDn reads
// over a req/ack memory port and strobes WRn writes. Optional macro: I8035_BUS_WAIT_EN (CPU stall on REQ).
module i8035_ext_bus_resp #(
  parameter int PROG_PAGE_W = 4,
  parameter int DATA_PAGE_W = 3
) (
  input  logic        I_CLK,
  input  logic        I_RSTn,
  input  logic        I_ALE,
  input  logic        I_PSENn,
  input  logic        I_RDn,
  input  logic        I_WRn,
  input  logic [7:0]  I_DB,
  input  logic [7:0]  I_P2,
  output logic [7:0]  O_DB,
  output logic        O_DB_OE,
  output logic        O_MEM_REQ,
  output logic        O_MEM_SPACE,
  output logic [11:0] O_MEM_ADDR,
  input  logic        I_MEM_ACK,
  input  logic [7:0]  I_MEM_DATA,
  output logic        O_WR_STB,
  output logic [10:0] O_WR_ADDR,
  output logic [7:0]  O_WR_DATA,
  output logic        O_LATE_ERR,
  output logic        O_CPU_HOLD
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic        psen_q, rd_q, wr_q;
  logic [7:0]  addr_lo_q;
  logic [1:0]  state_q, state_d;
  logic        space_q, space_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  db_q, db_d;
  logic        oe_q, oe_d;
  logic        late_err;
  logic [7:0]  wdata_q;
  logic        wr_stb_q;
  logic [10:0] wr_addr_q;
  logic [7:0]  wr_data_q;

  logic        psen_fall, rd_fall, wr_rise;
  logic        strobe_lvl, strobe_rise;
  logic [11:0] prog_addr, data_addr;
  logic        unused_p2;

  assign psen_fall = psen_q & ~I_PSENn;
  assign rd_fall   = rd_q & ~I_RDn;
  assign wr_rise   = ~wr_q & I_WRn;

  // The strobe that opened the transaction owns it; space_q says which one.
  assign strobe_lvl  = space_q ? I_RDn : I_PSENn;
  assign strobe_rise = space_q ? (~rd_q & I_RDn) : (~psen_q & I_PSENn);

  assign prog_addr = 12'({I_P2[PROG_PAGE_W-1:0], addr_lo_q});
  assign data_addr = 12'({I_P2[DATA_PAGE_W-1:0], addr_lo_q});
  assign unused_p2 = ^I_P2;

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      psen_q    <= 1'b1;
      rd_q      <= 1'b1;
      wr_q      <= 1'b1;
      addr_lo_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, whatever the statement order.
      psen_q <= I_PSENn;
      rd_q   <= I_RDn;
      wr_q   <= I_WRn;
      if (I_ALE) addr_lo_q <= I_DB;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    state_d  = state_q;
    space_d  = space_q;
    addr_d   = addr_q;
    db_d     = db_q;
    oe_d     = oe_q;
    late_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (psen_fall) begin
          state_d = ST_REQ;
          space_d = 1'b0;
          addr_d  = prog_addr;
        end else if (rd_fall) begin
          state_d = ST_REQ;
          space_d = 1'b1;
          addr_d  = data_addr;
        end
      end
      ST_REQ: begin
        if (I_MEM_ACK) begin
          if (!strobe_lvl) begin
            db_d    = I_MEM_DATA;
            oe_d    = 1'b1;
            state_d = ST_DRIVE;
          end else begin
            // Ack landing on the very cycle the strobe ends is still too late.
            late_err = 1'b1;
            state_d  = ST_IDLE;
          end
        end else if (strobe_rise) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRIVE: begin
        if (strobe_rise) begin
          oe_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (I_MEM_ACK) begin
          late_err = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q <= ST_IDLE;
      space_q <= 1'b0;
      addr_q  <= '0;
      db_q    <= 8'hFF;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      space_q <= space_d;
      addr_q  <= addr_d;
      db_q    <= db_d;
      oe_q    <= oe_d;
    end
  end

  // Write path runs independently of the read FSM; the page is sampled on the WRn rise.
  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      wdata_q   <= '0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      if (!I_WRn) wdata_q <= I_DB;
      wr_stb_q <= wr_rise;
      if (wr_rise) begin
        wr_addr_q <= 11'({I_P2[DATA_PAGE_W-1:0], addr_lo_q});
        wr_data_q <= wdata_q;
      end
    end
  end

  assign O_DB        = db_q;
  assign O_DB_OE     = oe_q;
  assign O_MEM_REQ   = (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign O_MEM_SPACE = space_q;
  assign O_MEM_ADDR  = addr_q;
  assign O_WR_STB    = wr_stb_q;
  assign O_WR_ADDR   = wr_addr_q;
  assign O_WR_DATA   = wr_data_q;
  assign O_LATE_ERR  = late_err;

`ifdef I8035_BUS_WAIT_EN
  assign O_CPU_HOLD = (state_q == ST_REQ);
`else
  assign O_CPU_HOLD = 1'b0;
`endif

endmodule

// File: tb/tb_i8035_ext_bus_resp.sv
// Randomized bench for i8035_ext_bus_resp: each transaction is described by its strobe window and ack
// cycle, and expected outputs per cycle are derived from those offsets.
module tb_i8035_ext_bus_resp;

`ifdef I8035_BUS_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic        I_CLK = 1'b0;
  logic        I_RSTn = 1'b0;
  logic        I_ALE, I_PSENn, I_RDn, I_WRn, I_MEM_ACK;
  logic [7:0]  I_DB, I_P2, I_MEM_DATA;
  logic [7:0]  O_DB, O_WR_DATA;
  logic        O_DB_OE, O_MEM_REQ, O_MEM_SPACE, O_WR_STB, O_LATE_ERR, O_CPU_HOLD;
  logic [11:0] O_MEM_ADDR;
  logic [10:0] O_WR_ADDR;

  i8035_ext_bus_resp dut (
    .I_CLK(I_CLK), .I_RSTn(I_RSTn), .I_ALE(I_ALE), .I_PSENn(I_PSENn), .I_RDn(I_RDn),
    .I_WRn(I_WRn), .I_DB(I_DB), .I_P2(I_P2), .O_DB(O_DB), .O_DB_OE(O_DB_OE),
    .O_MEM_REQ(O_MEM_REQ), .O_MEM_SPACE(O_MEM_SPACE), .O_MEM_ADDR(O_MEM_ADDR),
    .I_MEM_ACK(I_MEM_ACK), .I_MEM_DATA(I_MEM_DATA), .O_WR_STB(O_WR_STB),
    .O_WR_ADDR(O_WR_ADDR), .O_WR_DATA(O_WR_DATA), .O_LATE_ERR(O_LATE_ERR),
    .O_CPU_HOLD(O_CPU_HOLD)
  );

  always #5 I_CLK = ~I_CLK;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Expected outputs for the current cycle
  logic        exp_req, exp_oe, exp_late, exp_hold, exp_stb, exp_space;
  logic [7:0]  exp_db, exp_wr_data, model_db;
  logic [11:0] exp_addr;
  logic [10:0] exp_wr_addr;

  // Observation counters used by the literal checks
  int          req_rises, oe_cycles, late_cnt, stb_cnt, hold_cycles;
  logic        seen_space, prev_req;
  logic [11:0] seen_addr;
  logic [10:0] seen_wr_addr;
  logic [7:0]  seen_wr_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_idle_exp();
    exp_req = 1'b0; exp_oe = 1'b0; exp_late = 1'b0; exp_hold = 1'b0; exp_stb = 1'b0;
    exp_db = model_db; exp_space = 1'b0; exp_addr = '0; exp_wr_addr = '0; exp_wr_data = '0;
  endtask

  task automatic clear_counts();
    req_rises = 0; oe_cycles = 0; late_cnt = 0; stb_cnt = 0; hold_cycles = 0;
  endtask

  always @(negedge I_CLK) begin
    if (chk_en) begin
      check("mem_req", O_MEM_REQ, exp_req);
      check("db_oe", O_DB_OE, exp_oe);
      check("db", O_DB, exp_db);
      check("late_err", O_LATE_ERR, exp_late);
      check("cpu_hold", O_CPU_HOLD, exp_hold);
      check("wr_stb", O_WR_STB, exp_stb);
      if (exp_req) begin
        check("mem_space", O_MEM_SPACE, exp_space);
        check("mem_addr", O_MEM_ADDR, exp_addr);
      end
      if (exp_stb) begin
        check("wr_addr", O_WR_ADDR, exp_wr_addr);
        check("wr_data", O_WR_DATA, exp_wr_data);
      end
    end
  end

  always @(negedge I_CLK) begin
    if (O_MEM_REQ && !prev_req) req_rises++;
    if (O_MEM_REQ) begin
      seen_space = O_MEM_SPACE;
      seen_addr  = O_MEM_ADDR;
    end
    prev_req = O_MEM_REQ;
    if (O_DB_OE) oe_cycles++;
    if (O_LATE_ERR) late_cnt++;
    if (O_CPU_HOLD) hold_cycles++;
    if (O_WR_STB) begin
      stb_cnt++;
      seen_wr_addr = O_WR_ADDR;
      seen_wr_data = O_WR_DATA;
    end
  end

  // One bus cycle: ALE in cycle 0, strobes low in cycles 2..r-1 (r = 2+low_len), ack in cycle a = 3+ack_dly.
  task automatic run_tx(input bit use_psen, input bit use_rd, input bit use_wr,
                        input logic [7:0] lo, input logic [7:0] p2, input logic [7:0] dat,
                        input logic [7:0] wdat, input int low_len, input int ack_dly, input bit refall);
    bit         rd_tx, rf, low;
    int         r, a, last_c, req_end;
    logic [7:0] wexp;
    rd_tx   = use_psen | use_rd;
    r       = 2 + low_len;
    a       = rd_tx ? 3 + ack_dly : -10;
    last_c  = (rd_tx && a > r) ? a + 2 : r + 2;
    req_end = (a < r) ? a : r;
    rf      = refall && rd_tx && (a >= r + 3);
    wexp    = 8'h00;
    for (int c = 0; c <= last_c; c++) begin
      @(posedge I_CLK); #1;
      I_P2  = p2;
      I_ALE = (c == 0);
      I_DB  = (c == 0) ? lo : ((c == r - 1) ? wdat : 8'($urandom));
      low   = (c >= 2 && c < r) || (rf && c == r + 1);
      I_PSENn    = !(use_psen && low);
      I_RDn      = !(use_rd && low);
      I_WRn      = !(use_wr && c >= 2 && c < r);
      I_MEM_ACK  = rd_tx && (c == a);
      I_MEM_DATA = (c == a) ? dat : 8'($urandom);
      if (c == r - 1) wexp = I_DB;
      exp_req   = rd_tx && c >= 3 && c <= a;
      exp_hold  = WAIT_EN && rd_tx && c >= 3 && c <= req_end;
      exp_late  = rd_tx && a > r && c == a;
      exp_oe    = rd_tx && a < r && c > a && c <= r;
      if (rd_tx && a < r && c == a + 1) model_db = dat;
      exp_db    = model_db;
      exp_space = !use_psen;
      exp_addr  = use_psen ? {p2[3:0], lo} : {1'b0, p2[2:0], lo};
      exp_stb   = use_wr && c == r + 1;
      exp_wr_addr = {p2[2:0], lo};
      exp_wr_data = wexp;
    end
  endtask

  initial begin
    int          kind, low_len, ack_dly;
    bit          use_wr;
    I_ALE = 1'b0; I_PSENn = 1'b1; I_RDn = 1'b1; I_WRn = 1'b1;
    I_DB = '0; I_P2 = '0; I_MEM_ACK = 1'b0; I_MEM_DATA = '0;
    prev_req = 1'b0;
    model_db = 8'hFF;
    set_idle_exp();
    clear_counts();

    repeat (3) @(posedge I_CLK);
    #1;
    check("rst_db", O_DB, 8'hFF);
    check("rst_oe", O_DB_OE, 1'b0);
    check("rst_req", O_MEM_REQ, 1'b0);
    check("rst_addr", O_MEM_ADDR, 12'h000);
    check("rst_stb", O_WR_STB, 1'b0);
    check("rst_late", O_LATE_ERR, 1'b0);
    @(negedge I_CLK);
    I_RSTn = 1'b1;
    @(posedge I_CLK); #1;
    chk_en = 1'b1;

    // Program fetch, ack in the first REQ cycle
    clear_counts();
    run_tx(1'b1, 1'b0, 1'b0, 8'h34, 8'h05, 8'hA5, 8'h00, 6, 0, 1'b0);
    check("lit_prog_space", seen_space, 1'b0);
    check("lit_prog_addr", seen_addr, 12'h534);
    check("lit_prog_db", O_DB, 8'hA5);
    check("lit_prog_reqs", req_rises, 1);
    check("lit_prog_oe_cycles", oe_cycles, 5);

    // MOVX read
    clear_counts();
    run_tx(1'b0, 1'b1, 1'b0, 8'h10, 8'hFE, 8'h3C, 8'h00, 5, 1, 1'b0);
    check("lit_data_space", seen_space, 1'b1);
    check("lit_data_addr", seen_addr, 12'h610);
    check("lit_data_db", O_DB, 8'h3C);

    // MOVX write
    clear_counts();
    run_tx(1'b0, 1'b0, 1'b1, 8'h22, 8'h01, 8'h00, 8'h77, 4, 0, 1'b0);
    check("lit_wr_count", stb_cnt, 1);
    check("lit_wr_addr", seen_wr_addr, 11'h122);
    check("lit_wr_data", seen_wr_data, 8'h77);
    check("lit_wr_noreq", req_rises, 0);

    // PSENn and RDn together
    clear_counts();
    run_tx(1'b1, 1'b1, 1'b0, 8'h5A, 8'h0F, 8'hC3, 8'h00, 5, 0, 1'b0);
    check("lit_both_reqs", req_rises, 1);
    check("lit_both_space", seen_space, 1'b0);
    check("lit_both_addr", seen_addr, 12'hF5A);

    // Ack 10 cycles late, strobe gone after 4; a refall during the drain is ignored
    clear_counts();
    run_tx(1'b1, 1'b0, 1'b0, 8'h40, 8'h02, 8'h99, 8'h00, 4, 10, 1'b1);
    check("lit_late_pulses", late_cnt, 1);
    check("lit_late_no_oe", oe_cycles, 0);
    check("lit_late_reqs", req_rises, 1);
    check("lit_late_hold", hold_cycles, WAIT_EN ? 4 : 0);
    check("lit_late_db", O_DB, 8'hC3);

    // Async reset while a request is outstanding
    chk_en = 1'b0;
    @(posedge I_CLK); #1;
    I_ALE = 1'b1; I_DB = 8'h55; I_P2 = 8'h03;
    @(posedge I_CLK); #1;
    I_ALE = 1'b0; I_PSENn = 1'b0;
    repeat (3) @(posedge I_CLK);
    #1;
    check("rst_mid_pre_req", O_MEM_REQ, 1'b1);
    I_RSTn = 1'b0;
    #1;
    check("rst_mid_req", O_MEM_REQ, 1'b0);
    check("rst_mid_db", O_DB, 8'hFF);
    check("rst_mid_oe", O_DB_OE, 1'b0);
    check("rst_mid_addr", O_MEM_ADDR, 12'h000);
    @(posedge I_CLK); #1;
    I_PSENn = 1'b1;
    @(negedge I_CLK);
    I_RSTn = 1'b1;
    model_db = 8'hFF;
    set_idle_exp();
    @(posedge I_CLK); #1;
    chk_en = 1'b1;
    clear_counts();
    run_tx(1'b1, 1'b0, 1'b0, 8'h81, 8'h07, 8'h6E, 8'h00, 5, 0, 1'b0);
    check("lit_after_rst_addr", seen_addr, 12'h781);
    check("lit_after_rst_db", O_DB, 8'h6E);

    // Randomized traffic
    repeat (200) begin
      kind    = int'($urandom_range(0, 3));
      use_wr  = (kind == 3) || ($urandom_range(0, 3) == 0);
      low_len = int'($urandom_range(1, 8));
      ack_dly = int'($urandom_range(0, 10));
      if (ack_dly + 1 == low_len) ack_dly++;
      run_tx(kind == 0 || kind == 2, kind == 1 || kind == 2, use_wr,
             8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             low_len, ack_dly, 1'($urandom_range(0, 1)));
    end

    chk_en = 1'b0;
    @(posedge I_CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
